// File: rtl/int_ctrl.sv
// Coprocessor-0 interrupt controller: synchronizes int_req, holds STATUS/CAUSE/EPC/EBASE,
// and redirects the pipeline into the handler and back on ERET. Define CP_TIMER_EN for COUNT/COMPARE.
module int_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_000C,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        int_req,
    input  logic        take_en,
    input  logic        is_eret,
    input  logic        cp_wen,
    input  logic [4:0]  cp_addr_w,
    input  logic [31:0] cp_data_w,
    input  logic [4:0]  cp_addr_r,
    output logic [31:0] cp_data_r,
    input  logic [31:0] ret_addr,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        int_ack,
    output logic        in_isr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TAKE = 2'd1;
    localparam logic [1:0] S_ISR  = 2'd2;
    localparam logic [1:0] S_RET  = 2'd3;

    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] A_EBASE  = 5'd15;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   ie_q, ie_d, exl_q, exl_d, ip_q, ip_d;
    logic [31:0]            epc_q, epc_d, ebase_q, ebase_d;
    logic                   jump_en_q, jump_en_d, int_ack_q, int_ack_d;
    logic [31:0]            jump_addr_q, jump_addr_d;
    logic                   ti, irq, rise, take, eret;
    logic                   wr_status, wr_cause, wr_epc, wr_ebase;

    assign wr_status = cp_wen && (cp_addr_w == A_STATUS);
    assign wr_cause  = cp_wen && (cp_addr_w == A_CAUSE);
    assign wr_epc    = cp_wen && (cp_addr_w == A_EPC);
    assign wr_ebase  = cp_wen && (cp_addr_w == A_EBASE);

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign irq  = ip_q | ti;
    assign take = (state_q == S_IDLE) && irq && ie_q && !exl_q && take_en;
    assign eret = (state_q == S_ISR) && is_eret && take_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_TAKE;
            S_TAKE:  state_d = S_ISR;
            S_ISR:   if (eret) state_d = S_RET;
            default: state_d = S_IDLE;
        endcase

        ie_d  = wr_status ? cp_data_w[0] : ie_q;
        exl_d = take ? 1'b1 : (eret ? 1'b0 : exl_q);

        // A fresh edge beats any clear arriving in the same cycle.
        ip_d = ip_q;
        if (take || (wr_cause && !cp_data_w[10])) ip_d = 1'b0;
        if (rise) ip_d = 1'b1;

        epc_d   = take ? ret_addr : (wr_epc ? cp_data_w : epc_q);
        ebase_d = wr_ebase ? {cp_data_w[31:2], 2'b00} : ebase_q;

        jump_en_d   = take | eret;
        int_ack_d   = take;
        jump_addr_d = take ? ebase_q : (eret ? epc_q : jump_addr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            ie_q        <= 1'b0;
            exl_q       <= 1'b0;
            ip_q        <= 1'b0;
            epc_q       <= '0;
            ebase_q     <= HANDLER_ADDR;
            jump_en_q   <= 1'b0;
            int_ack_q   <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], int_req};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            ie_q        <= ie_d;
            exl_q       <= exl_d;
            ip_q        <= ip_d;
            epc_q       <= epc_d;
            ebase_q     <= ebase_d;
            jump_en_q   <= jump_en_d;
            int_ack_q   <= int_ack_d;
            jump_addr_q <= jump_addr_d;
        end
    end

`ifdef CP_TIMER_EN
    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;

    logic [31:0] count_q, compare_q;
    logic        ti_q;
    logic        wr_count, wr_compare, match;

    assign wr_count   = cp_wen && (cp_addr_w == A_COUNT);
    assign wr_compare = cp_wen && (cp_addr_w == A_COMPARE);
    assign match      = (count_q == compare_q) && (compare_q != 32'd0);

    // A match wins over the clear caused by a COMPARE write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= wr_count ? cp_data_w : count_q + 32'd1;
            compare_q <= wr_compare ? cp_data_w : compare_q;
            ti_q      <= match ? 1'b1 : (wr_compare ? 1'b0 : ti_q);
        end
    end

    assign ti = ti_q;
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        cp_data_r = '0;
        case (cp_addr_r)
            A_STATUS: cp_data_r = {30'd0, exl_q, ie_q};
            A_CAUSE:  cp_data_r = {1'b0, ti, 19'd0, ip_q, 10'd0};
            A_EPC:    cp_data_r = epc_q;
            A_EBASE:  cp_data_r = ebase_q;
`ifdef CP_TIMER_EN
            A_COUNT:   cp_data_r = count_q;
            A_COMPARE: cp_data_r = compare_q;
`endif
            default:  cp_data_r = '0;
        endcase
    end

    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;
    assign int_ack   = int_ack_q;
    assign in_isr    = exl_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, take latency, masking, ERET, nesting, EBASE and timer.
module tb_int_ctrl;

    logic        clk;
    logic        rst_n;
    logic        int_req;
    logic        take_en;
    logic        is_eret;
    logic        cp_wen;
    logic [4:0]  cp_addr_w;
    logic [31:0] cp_data_w;
    logic [4:0]  cp_addr_r;
    logic [31:0] cp_data_r;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        int_ack;
    logic        in_isr;

    int tests;
    int fails;
    logic seen;

    int_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .int_req   (int_req),
        .take_en   (take_en),
        .is_eret   (is_eret),
        .cp_wen    (cp_wen),
        .cp_addr_w (cp_addr_w),
        .cp_data_w (cp_data_w),
        .cp_addr_r (cp_addr_r),
        .cp_data_r (cp_data_r),
        .ret_addr  (ret_addr),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .int_ack   (int_ack),
        .in_isr    (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cp_addr_r = a;
        #1;
        chk(tag, cp_data_r, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp_wen    = 1'b1;
        cp_addr_w = a;
        cp_data_w = d;
        step();
        cp_wen    = 1'b0;
    endtask

    task automatic pulse_irq();
        int_req = 1'b1;
        step();
        int_req = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; int_req = 1'b0; take_en = 1'b0; is_eret = 1'b0;
        cp_wen = 1'b0; cp_addr_w = '0; cp_data_w = '0; cp_addr_r = '0; ret_addr = '0;
        step(); step();
        chk("rst_jump_en", {31'd0, jump_en}, 32'd0);
        chk("rst_jump_addr", jump_addr, 32'd0);
        chk("rst_int_ack", {31'd0, int_ack}, 32'd0);
        chk("rst_in_isr", {31'd0, in_isr}, 32'd0);
        rd(5'd15, 32'h0000_000C, "rst_ebase");
        rst_n = 1'b1;
        step();

        // Basic take: jump visible SYNC_STAGES+1 edges after int_req is sampled
        mtc0(5'd12, 32'd1);
        rd(5'd12, 32'd1, "status_ie");
        take_en = 1'b1; ret_addr = 32'h40;
        pulse_irq();
        chk("take_n1", {31'd0, jump_en}, 32'd0);
        step();
        chk("take_n2", {31'd0, jump_en}, 32'd0);
        step();
        rd(5'd13, 32'h400, "ip_set");
        chk("take_n3", {31'd0, jump_en}, 32'd0);
        step();
        chk("take_jump_en", {31'd0, jump_en}, 32'd1);
        chk("take_jump_addr", jump_addr, 32'h0C);
        chk("take_ack", {31'd0, int_ack}, 32'd1);
        chk("take_in_isr", {31'd0, in_isr}, 32'd1);
        rd(5'd14, 32'h40, "take_epc");
        rd(5'd13, 32'h0, "take_ip_clr");
        step();
        chk("take_jump_drop", {31'd0, jump_en}, 32'd0);
        chk("take_ack_drop", {31'd0, int_ack}, 32'd0);
        rd(5'd12, 32'd3, "isr_status");

        // ERET back to EPC, then an ERET outside ISR
        is_eret = 1'b1;
        step();
        chk("eret_jump_en", {31'd0, jump_en}, 32'd1);
        chk("eret_jump_addr", jump_addr, 32'h40);
        chk("eret_in_isr", {31'd0, in_isr}, 32'd0);
        is_eret = 1'b0;
        step();
        chk("eret_jump_drop", {31'd0, jump_en}, 32'd0);
        is_eret = 1'b1;
        step();
        chk("eret_idle_ignored", {31'd0, jump_en}, 32'd0);
        chk("eret_idle_isr", {31'd0, in_isr}, 32'd0);
        is_eret = 1'b0;

        // Masking with IE=0, then enabling IE takes on the following edge
        mtc0(5'd12, 32'd0);
        pulse_irq();
        seen = 1'b0;
        repeat (4) begin
            step();
            seen = seen | jump_en;
        end
        chk("mask_nojump", {31'd0, seen}, 32'd0);
        rd(5'd13, 32'h400, "mask_cause");
        ret_addr = 32'h80;
        mtc0(5'd12, 32'd1);
        chk("mask_prewrite_ie", {31'd0, jump_en}, 32'd0);
        step();
        chk("unmask_jump_en", {31'd0, jump_en}, 32'd1);
        chk("unmask_jump_addr", jump_addr, 32'h0C);
        rd(5'd14, 32'h80, "unmask_epc");
        step();

        // Nested request during ISR stays pending
        ret_addr = 32'hC0;
        pulse_irq();
        repeat (4) step();
        rd(5'd13, 32'h400, "nest_pending");
        chk("nest_in_isr", {31'd0, in_isr}, 32'd1);
        chk("nest_nojump", {31'd0, jump_en}, 32'd0);

        // EBASE write: same-cycle read shows old value, low bits forced to 0
        cp_wen = 1'b1; cp_addr_w = 5'd15; cp_data_w = 32'h203;
        cp_addr_r = 5'd15;
        #1;
        chk("ebase_old", cp_data_r, 32'h0C);
        step();
        cp_wen = 1'b0;
        rd(5'd15, 32'h200, "ebase_new");
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, 32'h0, "unmapped");

        is_eret = 1'b1;
        step();
        is_eret = 1'b0;
        chk("nest_ret_jump", {31'd0, jump_en}, 32'd1);
        chk("nest_ret_addr", jump_addr, 32'h80);
        step();
        chk("no_back_to_back", {31'd0, jump_en}, 32'd0);
        step();
        chk("nest_take_jump", {31'd0, jump_en}, 32'd1);
        chk("nest_take_addr", jump_addr, 32'h200);
        chk("nest_take_ack", {31'd0, int_ack}, 32'd1);
        rd(5'd14, 32'hC0, "nest_epc");
        step();

        // Reset in the middle of ISR
        rst_n = 1'b0;
        #1;
        chk("mid_rst_jump_en", {31'd0, jump_en}, 32'd0);
        chk("mid_rst_jump_addr", jump_addr, 32'd0);
        chk("mid_rst_ack", {31'd0, int_ack}, 32'd0);
        chk("mid_rst_in_isr", {31'd0, in_isr}, 32'd0);
        rd(5'd15, 32'h0000_000C, "mid_rst_ebase");
        rd(5'd14, 32'h0, "mid_rst_epc");
        rd(5'd12, 32'h0, "mid_rst_status");
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_jump", {31'd0, jump_en}, 32'd0);

`ifdef CP_TIMER_EN
        mtc0(5'd12, 32'd1);
        mtc0(5'd11, 32'd100);
        mtc0(5'd9, 32'd90);
        rd(5'd9, 32'd90, "tmr_count_wr");
        repeat (10) step();
        rd(5'd9, 32'd100, "tmr_count_100");
        rd(5'd13, 32'h0, "tmr_ti_not_yet");
        step();
        rd(5'd13, 32'h4000_0000, "tmr_ti_set");
        chk("tmr_nojump_yet", {31'd0, jump_en}, 32'd0);
        step();
        chk("tmr_take", {31'd0, jump_en}, 32'd1);
        chk("tmr_ack", {31'd0, int_ack}, 32'd1);
        mtc0(5'd11, 32'd0);
        rd(5'd13, 32'h0, "tmr_ti_clr");
`else
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd5);
        rd(5'd9, 32'h0, "notmr_count");
        rd(5'd11, 32'h0, "notmr_compare");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
